// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 data memory with load/store unit and a request/response
// handshake. Byte/half/word access, sign/zero extension, byte-lane writes and
// WAIT_STATES extra cycles between accept and response.
// Optional build macro: MISALIGN_CHECK_EN turns misaligned half/word accesses
// into error responses. When it is undefined, half accesses ignore ADDR[0] and
// word accesses ignore ADDR[1:0].
module data_mem_lsu #(
   parameter int ADDRESS_SIZE = 1024,
   parameter int A_S          = $clog2(ADDRESS_SIZE),
   parameter int WAIT_STATES  = 0
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           REQ_VALID,
   output logic           REQ_READY,
   input  logic           REQ_WE,
   input  logic [2:0]     REQ_FUNCT3,
   input  logic [A_S+1:0] REQ_ADDR,
   input  logic [31:0]    REQ_WDATA,
   output logic           RSP_VALID,
   output logic [31:0]    RSP_RDATA,
   output logic           RSP_ERR
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam bit         DIRECT   = (WAIT_STATES == 0);

   state_t           state, next_state;
   logic [3:0]       cnt;
   logic             accept, enter_resp;

   logic             q_we;
   logic [2:0]       q_f3;
   logic [A_S+1:0]   q_addr;
   logic [31:0]      q_wdata;

   logic             sel_we;
   logic [2:0]       sel_f3;
   logic [A_S+1:0]   sel_addr;
   logic [31:0]      sel_wdata;

   logic [31:0]      mem [ADDRESS_SIZE];
   logic [31:0]      word;
   logic [1:0]       lane;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic             legal, mis, dec_err;
   logic [3:0]       be;
   logic [31:0]      st_data, ld_data;

   // Handshake: ready whenever not busy counting wait states and not in reset
   always_comb begin
      REQ_READY = !RST && (state == S_IDLE || state == S_RESP);
      accept    = REQ_VALID && REQ_READY;
   end

   // Next-state logic; entering RESP is the single commit/response point
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = DIRECT ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
         S_RESP:  next_state = accept ? (DIRECT ? S_RESP : S_WAIT) : S_IDLE;
         default: next_state = S_IDLE;
      endcase
      enter_resp = (next_state == S_RESP) && !RST;
   end

   // With no wait states the commit edge is also the accept edge, so the live
   // request is used; otherwise the request registered at accept is used.
   always_comb begin
      sel_we    = DIRECT ? REQ_WE     : q_we;
      sel_f3    = DIRECT ? REQ_FUNCT3 : q_f3;
      sel_addr  = DIRECT ? REQ_ADDR   : q_addr;
      sel_wdata = DIRECT ? REQ_WDATA  : q_wdata;
   end

   // Access decode: legality, alignment, store lane enables and load extension
   always_comb begin
      word    = mem[sel_addr[A_S+1:2]];
      lane    = sel_addr[1:0];
      ld_byte = word[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? word[31:16] : word[15:0];
      legal   = sel_we ? (sel_f3 inside {3'b000, 3'b001, 3'b010})
                       : (sel_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef MISALIGN_CHECK_EN
      mis     = ((sel_f3[1:0] == 2'b01) && lane[0]) ||
                ((sel_f3[1:0] == 2'b10) && (lane != 2'b00));
`else
      mis     = 1'b0;
`endif
      dec_err = !legal || mis;
      be      = '0;
      st_data = '0;
      ld_data = '0;
      case (sel_f3)
         3'b000: begin
            be      = 4'b0001 << lane;
            st_data = {4{sel_wdata[7:0]}};
            ld_data = {{24{ld_byte[7]}}, ld_byte};
         end
         3'b001: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{sel_wdata[15:0]}};
            ld_data = {{16{ld_half[15]}}, ld_half};
         end
         3'b010: begin
            be      = '1;
            st_data = sel_wdata;
            ld_data = word;
         end
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = '0;
      endcase
   end

   // Control state, wait counter and response registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         RSP_ERR   <= 1'b0;
      end else begin
         state     <= next_state;
         if (accept)
            cnt <= CNT_INIT;
         else if (state == S_WAIT)
            cnt <= cnt - 4'd1;
         RSP_VALID <= enter_resp;
         if (enter_resp) begin
            RSP_RDATA <= (dec_err || sel_we) ? '0 : ld_data;
            RSP_ERR   <= dec_err;
         end
      end
   end

   // Request capture at accept (no reset needed: only read after an accept)
   always_ff @(posedge CLK) begin
      if (accept) begin
         q_we    <= REQ_WE;
         q_f3    <= REQ_FUNCT3;
         q_addr  <= REQ_ADDR;
         q_wdata <= REQ_WDATA;
      end
   end

   // RAM byte-lane writes on the commit edge; contents survive reset
   always_ff @(posedge CLK) begin
      if (enter_resp && sel_we && !dec_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[sel_addr[A_S+1:2]][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one instance with no wait states and one with three,
// directed scenarios followed by random traffic against a byte-array model.
module tb_data_mem_lsu;

   logic        clk = 1'b0;
   logic        rst0, v0, we0, rdy0, rv0, re0;
   logic [2:0]  f30;
   logic [7:0]  a0;
   logic [31:0] wd0, rd0;
   logic        rst3, v3, we3, rdy3, rv3, re3;
   logic [2:0]  f33;
   logic [7:0]  a3;
   logic [31:0] wd3, rd3;

   int checks = 0;
   int errors = 0;

   logic [7:0] mdl [2][64];

   always #5 clk = ~clk;

   data_mem_lsu #(.ADDRESS_SIZE(64), .WAIT_STATES(0)) u_dut0 (
      .CLK(clk), .RST(rst0), .REQ_VALID(v0), .REQ_READY(rdy0), .REQ_WE(we0),
      .REQ_FUNCT3(f30), .REQ_ADDR(a0), .REQ_WDATA(wd0),
      .RSP_VALID(rv0), .RSP_RDATA(rd0), .RSP_ERR(re0));

   data_mem_lsu #(.ADDRESS_SIZE(64), .WAIT_STATES(3)) u_dut3 (
      .CLK(clk), .RST(rst3), .REQ_VALID(v3), .REQ_READY(rdy3), .REQ_WE(we3),
      .REQ_FUNCT3(f33), .REQ_ADDR(a3), .REQ_WDATA(wd3),
      .RSP_VALID(rv3), .RSP_RDATA(rd3), .RSP_ERR(re3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Byte-addressed reference: size from funct3, little-endian assembly.
   function automatic void model(input int d, input bit we, input bit [2:0] f3,
                                 input int unsigned addr, input logic [31:0] wd,
                                 output bit err, output logic [31:0] rd);
      int unsigned size, base;
      logic [31:0] val;
      err = 1'b0;
      rd  = '0;
      size = 1 << f3[1:0];
      if (we ? !(f3 inside {0, 1, 2}) : !(f3 inside {0, 1, 2, 4, 5})) begin
         err = 1'b1;
         return;
      end
`ifdef MISALIGN_CHECK_EN
      if (addr % size != 0) begin
         err = 1'b1;
         return;
      end
`endif
      base = addr - (addr % size);
      if (we) begin
         for (int unsigned i = 0; i < size; i++) mdl[d][base+i] = 8'(wd >> (8*i));
      end else begin
         val = '0;
         for (int unsigned i = 0; i < size; i++) val = val | (32'(mdl[d][base+i]) << (8*i));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val - (32'd1 << (8*size));
         rd = val;
      end
   endfunction

   // One transaction; d=0 targets the zero-wait instance, d=1 the 3-wait one.
   task automatic xact(input int d, input bit we, input bit [2:0] f3, input logic [7:0] addr,
                       input logic [31:0] wd, input bit use_model,
                       input bit exp_err, input logic [31:0] exp_rd);
      bit me;
      logic [31:0] mr;
      int ws;
      ws = (d == 0) ? 0 : 3;
      model(d, we, f3, 32'(addr), wd, me, mr);
      if (use_model) begin
         exp_err = me;
         exp_rd  = mr;
      end
      if (d == 0) begin
         v0 = 1'b1; we0 = we; f30 = f3; a0 = addr; wd0 = wd;
         #0 chk("ready0", 32'(rdy0), 32'd1);
      end else begin
         v3 = 1'b1; we3 = we; f33 = f3; a3 = addr; wd3 = wd;
         #0 chk("ready3", 32'(rdy3), 32'd1);
      end
      @(posedge clk); #1;
      if (d == 0) v0 = 1'b0; else v3 = 1'b0;
      for (int k = 0; k < ws; k++) begin
         chk("wait_valid3", 32'(rv3), 32'd0);
         chk("wait_ready3", 32'(rdy3), 32'd0);
         @(posedge clk); #1;
      end
      if (d == 0) begin
         chk("rsp_valid0", 32'(rv0), 32'd1);
         chk("rsp_err0", 32'(re0), 32'(exp_err));
         chk("rsp_rdata0", rd0, exp_rd);
      end else begin
         chk("rsp_valid3", 32'(rv3), 32'd1);
         chk("rsp_err3", 32'(re3), 32'(exp_err));
         chk("rsp_rdata3", rd3, exp_rd);
      end
   endtask

   initial begin
      rst0 = 1'b1; rst3 = 1'b1;
      v0 = 1'b0; we0 = 1'b0; f30 = '0; a0 = '0; wd0 = '0;
      v3 = 1'b0; we3 = 1'b0; f33 = '0; a3 = '0; wd3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid0", 32'(rv0), 32'd0);
      chk("reset_rdata0", rd0, 32'd0);
      chk("reset_err0", 32'(re0), 32'd0);
      chk("reset_ready0", 32'(rdy0), 32'd0);
      chk("reset_ready3", 32'(rdy3), 32'd0);
      rst0 = 1'b0; rst3 = 1'b0;

      // Zero wait states: back-to-back directed accesses on word 0x10
      xact(0, 1, 3'b010, 8'h10, 32'h11223344, 0, 0, 32'h0);
      xact(0, 0, 3'b010, 8'h10, 32'h0,        0, 0, 32'h11223344);
      xact(0, 1, 3'b000, 8'h13, 32'h000000AA, 0, 0, 32'h0);
      xact(0, 0, 3'b000, 8'h13, 32'h0,        0, 0, 32'hFFFFFFAA);
      xact(0, 0, 3'b100, 8'h13, 32'h0,        0, 0, 32'h000000AA);
      xact(0, 0, 3'b010, 8'h10, 32'h0,        0, 0, 32'hAA223344);
      xact(0, 1, 3'b001, 8'h12, 32'h00008001, 0, 0, 32'h0);
      xact(0, 0, 3'b001, 8'h12, 32'h0,        0, 0, 32'hFFFF8001);
      xact(0, 0, 3'b101, 8'h12, 32'h0,        0, 0, 32'h00008001);
      xact(0, 0, 3'b010, 8'h10, 32'h0,        0, 0, 32'h80013344);
`ifdef MISALIGN_CHECK_EN
      xact(0, 1, 3'b010, 8'h11, 32'hDEADBEEF, 0, 1, 32'h0);
      xact(0, 0, 3'b010, 8'h10, 32'h0,        0, 0, 32'h80013344);
`else
      xact(0, 1, 3'b010, 8'h11, 32'hDEADBEEF, 0, 0, 32'h0);
      xact(0, 0, 3'b010, 8'h10, 32'h0,        0, 0, 32'hDEADBEEF);
`endif
      xact(0, 0, 3'b011, 8'h10, 32'h0,        0, 1, 32'h0);
      @(posedge clk); #1;
      chk("idle_valid0", 32'(rv0), 32'd0);
      chk("hold_err0", 32'(re0), 32'd1);
      chk("hold_rdata0", rd0, 32'd0);

      // Fill every word, then random traffic including illegal/misaligned ops
      for (int w = 0; w < 16; w++) xact(0, 1, 3'b010, 8'(4*w), $urandom, 1, 0, 0);
      for (int n = 0; n < 300; n++)
         xact(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 63)), $urandom, 1, 0, 0);

      // Three wait states: latency and reset while a store is pending
      xact(1, 1, 3'b010, 8'h20, 32'h55AA55AA, 1, 0, 0);
      xact(1, 0, 3'b010, 8'h20, 32'h0,        1, 0, 0);
      v3 = 1'b1; we3 = 1'b1; f33 = 3'b010; a3 = 8'h20; wd3 = 32'h12345678;
      @(posedge clk); #1;
      v3 = 1'b0;
      chk("pending_valid3", 32'(rv3), 32'd0);
      rst3 = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid3", 32'(rv3), 32'd0);
      chk("midrst_rdata3", rd3, 32'd0);
      chk("midrst_err3", 32'(re3), 32'd0);
      chk("midrst_ready3", 32'(rdy3), 32'd0);
      rst3 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("dropped_valid3", 32'(rv3), 32'd0);
      end
      xact(1, 0, 3'b010, 8'h20, 32'h0, 0, 0, 32'h55AA55AA);
      for (int w = 0; w < 16; w++) xact(1, 1, 3'b010, 8'(4*w), $urandom, 1, 0, 0);
      for (int n = 0; n < 60; n++)
         xact(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 63)), $urandom, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
